// File: rtl/button_reader_if.sv
// Button bundle between the board pins and the debouncer: raw levels in,
// clean levels, press/release pulses and the running press count out.
interface button_reader_if #(
  parameter int NUM_BUTTONS = 4
);

  logic [NUM_BUTTONS-1:0] btn;
  logic [NUM_BUTTONS-1:0] btn_state;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
  logic [7:0]             press_total;

  modport master (
    output btn,
    input  btn_state,
    input  btn_press,
    input  btn_release,
    input  press_total
  );

  modport slave (
    input  btn,
    output btn_state,
    output btn_press,
    output btn_release,
    output press_total
  );

endinterface

// File: rtl/button_reader.sv
// Debounced push-button reader: 2-flop synchronizer, per-button 4-state debounce
// FSM, registered one-cycle press/release pulses and a wrapping 8-bit press count.
module button_reader #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic            clock,
  input logic            reset_n,
  button_reader_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  logic [NUM_BUTTONS-1:0]            sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0][1:0]       state_q, state_d;
  logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0]            level_q, level_d;
  logic [NUM_BUTTONS-1:0]            press_q, press_d;
  logic [NUM_BUTTONS-1:0]            release_q, release_d;
  logic [7:0]                        total_q, total_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES identical samples;
  // any opposite sample in a WAIT state drops back without touching outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      case (state_q[i])
        RELEASED: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT_PRESS;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_PRESS: begin
          if (!sync2_q[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT_RELEASE;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_RELEASE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = RELEASED;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Count is bumped by the popcount of the pulses being registered this edge.
  always_comb begin
    total_d = total_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      total_d = total_d + {7'd0, press_d[i]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      total_q   <= total_d;
    end
  end

  assign bus.btn_state   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.press_total = total_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4: vector tables for the
// clean and bouncing presses, hand sequences for glitches, wrap and async reset.
module tb_button_reader;

  localparam int NB = 4;
  localparam int DB = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  typedef struct packed {
    logic [3:0] btn;
    logic [3:0] expState;
    logic [3:0] expPress;
    logic [3:0] expRelease;
    logic [7:0] expTotal;
  } vec_t;

  vec_t vecs[$];

  button_reader_if #(.NUM_BUTTONS(NB)) bus ();

  button_reader #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] st, input logic [3:0] pr,
                          input logic [3:0] rl, input logic [7:0] tot);
    checkOutput({tag, " state"},   {4'd0, bus.btn_state},   {4'd0, st});
    checkOutput({tag, " press"},   {4'd0, bus.btn_press},   {4'd0, pr});
    checkOutput({tag, " release"}, {4'd0, bus.btn_release}, {4'd0, rl});
    checkOutput({tag, " total"},   bus.press_total,         tot);
  endtask

  task automatic addVec(input logic [3:0] b, input logic [3:0] s, input logic [3:0] p,
                        input logic [3:0] r, input logic [7:0] t);
    vec_t v;
    v.btn        = b;
    v.expState   = s;
    v.expPress   = p;
    v.expRelease = r;
    v.expTotal   = t;
    vecs.push_back(v);
  endtask

  // Each vector is driven just after one edge and checked just after the next.
  task automatic applyStimulus(input string tag);
    for (int k = 0; k < vecs.size(); k++) begin
      bus.btn = vecs[k].btn;
      tick();
      checkAll($sformatf("%s[%0d]", tag, k + 1), vecs[k].expState, vecs[k].expPress,
               vecs[k].expRelease, vecs[k].expTotal);
    end
    vecs.delete();
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n = 1'b0;
    bus.btn = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [6:0] bouncePat;
    logic       b1;
    bus.btn = '0;
    #1 reset_n = 1'b0;
    #2;
    checkAll("reset", 4'h0, 4'h0, 4'h0, 8'd0);
    doReset();

    // Clean press on button 0: accepted after edge 6, released 6 edges after first low.
    for (int k = 1; k <= 30; k++) begin
      addVec({3'b000, 1'(k <= 20)}, {3'b000, 1'(k >= 6 && k <= 25)},
             {3'b000, 1'(k == 6)}, {3'b000, 1'(k == 26)}, 8'(k >= 6));
    end
    applyStimulus("clean");

    // Button 1 bounces while button 0 repeats the clean press.
    doReset();
    bouncePat = 7'b0110111;
    for (int k = 1; k <= 30; k++) begin
      b1 = (k <= 7) ? bouncePat[k-1] : 1'b1;
      addVec({2'b00, b1, 1'(k <= 20)},
             {2'b00, 1'(k >= 13), 1'(k >= 6 && k <= 25)},
             {2'b00, 1'(k == 13), 1'(k == 6)},
             {3'b000, 1'(k == 26)},
             8'(k >= 6) + 8'(k >= 13));
    end
    applyStimulus("bounce");

    doReset();
    for (int c = 0; c < 50; c++) begin
      bus.btn = {1'b0, 1'(c % 3 == 0), 2'b00};
      tick();
      checkAll($sformatf("glitch[%0d]", c), 4'h0, 4'h0, 4'h0, 8'd0);
    end
    bus.btn = '0;
    repeat (4) tick();

    for (int n = 0; n < 254; n++) begin
      bus.btn = 4'b0001;
      repeat (6) tick();
      bus.btn = 4'b0000;
      repeat (7) tick();
    end
    checkAll("wrap pre", 4'h0, 4'h0, 4'h0, 8'd254);
    bus.btn = 4'b1111;
    repeat (5) tick();
    checkAll("wrap e5", 4'h0, 4'h0, 4'h0, 8'd254);
    tick();
    checkAll("wrap e6", 4'hF, 4'hF, 4'h0, 8'd2);
    tick();
    checkAll("wrap e7", 4'hF, 4'h0, 4'h0, 8'd2);

    bus.btn = 4'b0000;
    repeat (8) tick();
    checkAll("relall", 4'h0, 4'h0, 4'h0, 8'd2);

    // Button 0 is mid-debounce (cnt=2) when reset drops between edges.
    bus.btn = 4'b0001;
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    checkAll("async rst", 4'h0, 4'h0, 4'h0, 8'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkAll($sformatf("postrst[%0d]", k), {3'b000, 1'(k >= 6)},
               {3'b000, 1'(k == 6)}, 4'h0, 8'(k >= 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
